aes_gcm_ctr_sequencer: RTL

- Front-end stage of the AES-GCM pipeline. Sits immediately upstream of the H/J0/CB encryption stage and feeds its inputs.
- Accepts one instance header (IV, key schedule, lengths), then streams AAD and plaintext blocks.
- Per block, it emits the phase tag, the zero block for H, J0, and the incrementing counter block CB.
- Zero-pads partial final blocks and appends the final len(A)||len(C) beat.

---
 rtl/aes_gcm_ctr_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_gcm_ctr_sequencer.sv
// rtl/aes_gcm_ctr_sequencer.sv - AES-GCM front-end: header capture, AAD/PT beat sequencing, CB generation
// Optional length check enabled by defining AES_GCM_LEN_CHECK_EN (adds o_len_error).
module aes_gcm_ctr_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_new_instance,
  input  logic [95:0]   i_iv,
  input  logic [1407:0] i_key_schedule,
  input  logic [127:0]  i_instance_size,
  input  logic [127:0]  i_block,
  output logic          o_new_instance,
  output logic [2:0]    o_phase,
  output logic [127:0]  o_h,
  output logic [127:0]  o_j0,
  output logic [127:0]  o_cb,
  output logic [127:0]  o_plain_text,
  output logic [127:0]  o_aad,
  output logic [127:0]  o_instance_size,
  output logic [1407:0] o_key_schedule
`ifdef AES_GCM_LEN_CHECK_EN
  ,
  output logic          o_len_error
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_AAD  = 3'd2,
    S_PT   = 3'd3,
    S_LEN  = 3'd4
  } state_t;

  localparam logic [2:0] PH_BUBBLE = 3'd0;
  localparam logic [2:0] PH_INIT   = 3'd1;
  localparam logic [2:0] PH_AAD    = 3'd2;
  localparam logic [2:0] PH_PT     = 3'd3;
  localparam logic [2:0] PH_LEN    = 3'd4;

  // Keeps the first r bits of the block in GCM (MSB-first) order; r=0 means a full block.
  function automatic logic [127:0] tail_mask(input logic [127:0] blk, input logic [6:0] r);
    logic [127:0] keep;
    keep = ~({128{1'b1}} >> r);
    return (r == 7'd0) ? blk : (blk & keep);
  endfunction

  function automatic logic [CNT_W-1:0] ceil_blocks(input logic [63:0] len);
    logic [57:0] n;
    n = {1'b0, len[63:7]} + {57'd0, |len[6:0]};
    return n[CNT_W-1:0];
  endfunction

  state_t               state_q, state_d;
  logic [95:0]          iv_q, iv_d;
  logic [127:0]         cb_q, cb_d;
  logic [CNT_W-1:0]     aad_left_q, aad_left_d;
  logic [CNT_W-1:0]     pt_left_q, pt_left_d;

  logic                 ready_d;
  logic                 new_inst_d;
  logic [2:0]           phase_d;
  logic [127:0]         j0_d, cb_out_d, pt_d, aad_d, size_d;
  logic [1407:0]        key_d;
  logic                 len_err_d;

  logic                 accept;
  logic                 len_bad;
  logic [63:0]          len_a, len_c;

  assign accept = i_valid & o_ready;
  assign len_a  = o_instance_size[127:64];
  assign len_c  = o_instance_size[63:0];
  assign o_h    = '0;

`ifdef AES_GCM_LEN_CHECK_EN
  assign len_bad = (i_instance_size[63:0]   > 64'h0000_007F_FFFF_FF00) ||
                   (i_instance_size[127:64] > 64'hFFFF_FFFF_FFFF_FF80);
`else
  assign len_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    iv_d       = iv_q;
    cb_d       = cb_q;
    aad_left_d = aad_left_q;
    pt_left_d  = pt_left_q;
    new_inst_d = 1'b0;
    phase_d    = PH_BUBBLE;
    j0_d       = o_j0;
    cb_out_d   = o_cb;
    pt_d       = '0;
    aad_d      = '0;
    size_d     = o_instance_size;
    key_d      = o_key_schedule;
    len_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && i_new_instance) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            iv_d       = i_iv;
            key_d      = i_key_schedule;
            size_d     = i_instance_size;
            aad_left_d = ceil_blocks(i_instance_size[127:64]);
            pt_left_d  = ceil_blocks(i_instance_size[63:0]);
            state_d    = S_INIT;
          end
        end
      end
      S_INIT: begin
        new_inst_d = 1'b1;
        phase_d    = PH_INIT;
        j0_d       = {iv_q, 32'd1};
        cb_out_d   = {iv_q, 32'd2};
        cb_d       = {iv_q, 32'd2};
        if (aad_left_q != '0)     state_d = S_AAD;
        else if (pt_left_q != '0) state_d = S_PT;
        else                      state_d = S_LEN;
      end
      S_AAD: begin
        if (accept) begin
          phase_d    = PH_AAD;
          aad_left_d = aad_left_q - 1'b1;
          if (aad_left_q == CNT_W'(1)) begin
            aad_d   = tail_mask(i_block, len_a[6:0]);
            state_d = (pt_left_q != '0) ? S_PT : S_LEN;
          end else begin
            aad_d = i_block;
          end
        end
      end
      S_PT: begin
        if (accept) begin
          phase_d   = PH_PT;
          cb_out_d  = cb_q;
          // inc32: only the low word counts, the IV part never sees a carry
          cb_d      = {cb_q[127:32], cb_q[31:0] + 32'd1};
          pt_left_d = pt_left_q - 1'b1;
          if (pt_left_q == CNT_W'(1)) begin
            pt_d    = tail_mask(i_block, len_c[6:0]);
            state_d = S_LEN;
          end else begin
            pt_d = i_block;
          end
        end
      end
      S_LEN: begin
        phase_d = PH_LEN;
        aad_d   = o_instance_size;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_AAD) || (state_d == S_PT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      iv_q            <= '0;
      cb_q            <= '0;
      aad_left_q      <= '0;
      pt_left_q       <= '0;
      o_ready         <= 1'b0;
      o_new_instance  <= 1'b0;
      o_phase         <= PH_BUBBLE;
      o_j0            <= '0;
      o_cb            <= '0;
      o_plain_text    <= '0;
      o_aad           <= '0;
      o_instance_size <= '0;
      o_key_schedule  <= '0;
`ifdef AES_GCM_LEN_CHECK_EN
      o_len_error     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      iv_q            <= iv_d;
      cb_q            <= cb_d;
      aad_left_q      <= aad_left_d;
      pt_left_q       <= pt_left_d;
      o_ready         <= ready_d;
      o_new_instance  <= new_inst_d;
      o_phase         <= phase_d;
      o_j0            <= j0_d;
      o_cb            <= cb_out_d;
      o_plain_text    <= pt_d;
      o_aad           <= aad_d;
      o_instance_size <= size_d;
      o_key_schedule  <= key_d;
`ifdef AES_GCM_LEN_CHECK_EN
      o_len_error     <= len_err_d;
`endif
    end
  end

`ifndef AES_GCM_LEN_CHECK_EN
  logic unused_len_err;
  assign unused_len_err = len_err_d;
`endif

endmodule
